// File: rtl/aes_subbytes_iter.sv
`default_nettype none
// ============================================================================
//  Module      : aes_subbytes_iter (with helper sbox_combi)
//  Description : Iterative AES SubBytes / InvSubBytes over a NUM_BYTES block.
//                LANES S-boxes process LANES bytes per cycle across
//                NUM_BYTES/LANES beats. Uses a valid/ready handshake on both
//                the input side and the output side.
//  Revision    : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// Combinational AES S-box. en_or_de = 1 selects the forward box and
// en_or_de = 0 selects the inverse box. It is computed algebraically from the
// GF(2^8) inverse and the affine transform, so no ROM table is needed.
// ----------------------------------------------------------------------------
module sbox_combi (
    input  logic       en_or_de,
    input  logic [7:0] data_in,
    output logic [7:0] data_out
);

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        logic [7:0] m;
        p = 8'h00;
        t = a;
        m = b;
        for (int i = 0; i < 8; i++) begin
            if (m[0]) begin
                p = p ^ t;
            end
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
            m = {1'b0, m[7:1]};
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0, as AES requires)
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = x;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    // Forward affine map: b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63
    function automatic logic [7:0] affine_fwd(input logic [7:0] a);
        return a ^ {a[6:0], a[7]} ^ {a[5:0], a[7:6]} ^ {a[4:0], a[7:5]}
                 ^ {a[3:0], a[7:4]} ^ 8'h63;
    endfunction

    // Inverse affine map: rotl1 ^ rotl3 ^ rotl6 ^ 0x05
    function automatic logic [7:0] affine_inv(input logic [7:0] a);
        return {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    endfunction

    // Select the forward or inverse substitution
    always_comb begin
        data_out = en_or_de ? affine_fwd(gf_inv(data_in)) : gf_inv(affine_inv(data_in));
    end

endmodule

// ----------------------------------------------------------------------------
// Iterative SubBytes engine
// ----------------------------------------------------------------------------
module aes_subbytes_iter #(
    parameter int NUM_BYTES = 16,
    parameter int LANES     = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   en_or_de,
    input  logic [8*NUM_BYTES-1:0] data_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [8*NUM_BYTES-1:0] data_out,
    output logic                   busy
);

    // Guarded lane count keeps the derived constants legal while the
    // parameter check below reports the real problem.
    localparam int SAFE_LANES = (LANES >= 1) ? LANES : 1;
    localparam int BEATS      = NUM_BYTES / SAFE_LANES;
    localparam int CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int BEAT_W     = 8 * SAFE_LANES;

    localparam logic [CNT_W-1:0] c_last_beat = CNT_W'(BEATS - 1);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_busy = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    generate
        if (LANES < 1 || NUM_BYTES < 1 || (NUM_BYTES % SAFE_LANES) != 0) begin : g_param_check
            $error("aes_subbytes_iter: NUM_BYTES must be a positive multiple of LANES (LANES >= 1)");
        end
    endgenerate

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_beat;
    logic              r_mode;
    logic [BEAT_W-1:0] r_data   [BEATS];
    logic [BEAT_W-1:0] r_result [BEATS];

    logic [BEAT_W-1:0] w_in_beats [BEATS];
    logic [BEAT_W-1:0] w_cur;
    logic [BEAT_W-1:0] w_sub;
    logic              w_accept;

    assign in_ready  = (r_state == c_idle);
    assign out_valid = (r_state == c_done);
    assign busy      = (r_state != c_idle);
    assign w_accept  = in_valid & in_ready;

    // Bytes of the current beat, taken from the latched copy of the block
    assign w_cur = r_data[r_beat];

    // Slice the flat ports into per-beat groups of LANES bytes
    generate
        for (genvar b = 0; b < BEATS; b++) begin : g_beat
            assign w_in_beats[b]                  = data_in[b*BEAT_W +: BEAT_W];
            assign data_out[b*BEAT_W +: BEAT_W]   = r_result[b];
        end
    endgenerate

    // One S-box per lane, all steered by the latched mode
    generate
        for (genvar j = 0; j < SAFE_LANES; j++) begin : g_lane
            sbox_combi u_sbox (
                .en_or_de (r_mode),
                .data_in  (w_cur[j*8 +: 8]),
                .data_out (w_sub[j*8 +: 8])
            );
        end
    endgenerate

    // Control FSM: IDLE -> BUSY (BEATS cycles) -> DONE -> IDLE on handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_idle;
            r_beat  <= '0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (w_accept) begin
                        r_state <= c_busy;
                        r_beat  <= '0;
                    end
                end
                c_busy: begin
                    if (r_beat == c_last_beat) begin
                        r_state <= c_done;
                        r_beat  <= '0;
                    end else begin
                        r_beat <= r_beat + CNT_W'(1);
                    end
                end
                c_done: begin
                    // Return to IDLE only; the next accept needs IDLE first
                    if (out_ready) begin
                        r_state <= c_idle;
                    end
                end
                default: begin
                    r_state <= c_idle;
                    r_beat  <= '0;
                end
            endcase
        end
    end

    // Capture block and mode on accept so later input changes are ignored
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode <= 1'b1;
            r_data <= '{default: '0};
        end else if (w_accept) begin
            r_mode <= en_or_de;
            r_data <= w_in_beats;
        end
    end

    // Write one beat of substituted bytes; result holds outside BUSY
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '{default: '0};
        end else if (r_state == c_busy) begin
            r_result[r_beat] <= w_sub;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_aes_subbytes_iter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes_subbytes_iter
//  Description : Self-checking bench for aes_subbytes_iter. Instance 0 uses the
//                default LANES=4; instances 1..3 use LANES = 1, 2, 16.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_subbytes_iter;

    localparam int NI = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [NI-1:0]  in_valid;
    logic [NI-1:0]  in_ready;
    logic [NI-1:0]  en_or_de;
    logic [NI-1:0]  out_valid;
    logic [NI-1:0]  out_ready;
    logic [NI-1:0]  busy;
    logic [127:0]   data_in  [NI];
    logic [127:0]   data_out [NI];

    int checks = 0;
    int errors = 0;

    logic [7:0] fwd_tab [256];
    logic [7:0] inv_tab [256];

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < NI; g++) begin : g_dut
            aes_subbytes_iter #(
                .NUM_BYTES (16),
                .LANES     ((g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 2 : 16)
            ) u_dut (
                .clk       (clk),
                .rst_n     (rst_n),
                .in_valid  (in_valid[g]),
                .in_ready  (in_ready[g]),
                .en_or_de  (en_or_de[g]),
                .data_in   (data_in[g]),
                .out_valid (out_valid[g]),
                .out_ready (out_ready[g]),
                .data_out  (data_out[g]),
                .busy      (busy[g])
            );
        end
    endgenerate

    function automatic int lanes_of(input int i);
        return (i == 0) ? 4 : (i == 1) ? 1 : (i == 2) ? 2 : 16;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [7:0] r;
        r = v;
        for (int k = 0; k < n; k++) r = {r[6:0], r[7]};
        return r;
    endfunction

    // Reference S-boxes from exp/log tables of generator 3
    task automatic build_model();
        logic [7:0] ex [256];
        int         lg [256];
        logic [7:0] v;
        logic [7:0] iv;
        logic [7:0] s;
        v = 8'h01;
        for (int i = 0; i < 255; i++) begin
            ex[i] = v;
            lg[v] = i;
            v = v ^ ({v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00));
        end
        for (int x = 0; x < 256; x++) begin
            iv = (x == 0) ? 8'h00 : ex[(255 - lg[x]) % 255];
            s  = iv ^ rotl8(iv, 1) ^ rotl8(iv, 2) ^ rotl8(iv, 3) ^ rotl8(iv, 4) ^ 8'h63;
            fwd_tab[x] = s;
            inv_tab[s] = x[7:0];
        end
    endtask

    function automatic logic [127:0] model(input logic mode, input logic [127:0] d);
        logic [127:0] r;
        logic [7:0]   bt;
        r = '0;
        for (int b = 0; b < 16; b++) begin
            bt = d[8*b +: 8];
            r[8*b +: 8] = mode ? fwd_tab[bt] : inv_tab[bt];
        end
        return r;
    endfunction

    function automatic logic [127:0] rand_block();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Send one block, disturb inputs during BUSY, check latency and result
    task automatic run_block(input int idx, input logic mode, input logic [127:0] din,
                             input logic [127:0] exp, input string name);
        int cnt;
        cnt = 0;
        while (!in_ready[idx] && cnt < 40) begin tick(); cnt++; end
        check({name, " in_ready"}, 128'(in_ready[idx]), 128'(1));
        in_valid[idx]  = 1'b1;
        data_in[idx]   = din;
        en_or_de[idx]  = mode;
        out_ready[idx] = 1'b0;
        tick();
        in_valid[idx] = 1'($urandom_range(0, 1));
        data_in[idx]  = rand_block();
        en_or_de[idx] = ~mode;
        cnt = 0;
        while (!out_valid[idx] && cnt < 40) begin tick(); cnt++; end
        check({name, " latency"}, 128'(cnt), 128'(16 / lanes_of(idx)));
        check({name, " data"}, data_out[idx], exp);
        in_valid[idx]  = 1'b0;
        out_ready[idx] = 1'b1;
        tick();
        out_ready[idx] = 1'b0;
        check({name, " out_valid drop"}, 128'(out_valid[idx]), 128'(0));
    endtask

    typedef struct {
        logic         mode;
        logic [127:0] din;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic [127:0] d1, d2, held;
        int           cnt, bad;

        vecs[0] = '{1'b1, 128'h0f0e0d0c0b0a09080706050403020100, 128'h76abd7fe2b670130c56f6bf27b777c63};
        vecs[1] = '{1'b0, {16{8'h63}}, {16{8'h00}}};
        vecs[2] = '{1'b0, {16{8'h00}}, {16{8'h52}}};
        vecs[3] = '{1'b0, {16{8'hed}}, {16{8'h53}}};
        vecs[4] = '{1'b1, {16{8'h53}}, {16{8'hed}}};
        vecs[5] = '{1'b0, 128'h76abd7fe2b670130c56f6bf27b777c63, 128'h0f0e0d0c0b0a09080706050403020100};

        rst_n     = 1'b0;
        in_valid  = '0;
        en_or_de  = '0;
        out_ready = '0;
        for (int i = 0; i < NI; i++) data_in[i] = '0;
        build_model();

        // Reset state
        #12;
        check("rst out_valid", 128'(out_valid[0]), 128'(0));
        check("rst busy", 128'(busy[0]), 128'(0));
        check("rst data_out", data_out[0], 128'(0));
        check("rst in_ready", 128'(in_ready[0]), 128'(1));
        tick();
        rst_n = 1'b1;

        // Table vectors on the default configuration
        for (int v = 0; v < 6; v++) begin
            run_block(0, vecs[v].mode, vecs[v].din, vecs[v].exp, $sformatf("vec%0d", v));
        end

        // Random blocks against the reference model
        for (int r = 0; r < 20; r++) begin
            logic         m;
            logic [127:0] d;
            m = 1'($urandom_range(0, 1));
            d = rand_block();
            run_block(0, m, d, model(m, d), $sformatf("rand%0d", r));
        end

        // Output back-pressure: DONE holds, input blocked until after handshake
        d1 = rand_block();
        d2 = rand_block();
        in_valid[0] = 1'b1; data_in[0] = d1; en_or_de[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        cnt = 0;
        while (!out_valid[0] && cnt < 40) begin tick(); cnt++; end
        check("bp latency", 128'(cnt), 128'(4));
        held = data_out[0];
        check("bp data", held, model(1'b1, d1));
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (i >= 5) begin
                in_valid[0] = 1'b1;
                data_in[0]  = rand_block();
                en_or_de[0] = 1'($urandom_range(0, 1));
            end
            tick();
            if (out_valid[0] !== 1'b1 || data_out[0] !== held || in_ready[0] !== 1'b0) bad++;
        end
        check("bp hold cycles bad", 128'(bad), 128'(0));
        out_ready[0] = 1'b1;
        data_in[0]   = rand_block();
        tick();
        out_ready[0] = 1'b0;
        check("bp out_valid after hs", 128'(out_valid[0]), 128'(0));
        check("bp no accept on hs", 128'(busy[0]), 128'(0));
        check("bp in_ready after hs", 128'(in_ready[0]), 128'(1));
        check("bp idle hold", data_out[0], held);
        data_in[0] = d2; en_or_de[0] = 1'b0;
        tick();
        in_valid[0] = 1'b0;
        check("bp accept next", 128'(busy[0]), 128'(1));
        cnt = 0;
        while (!out_valid[0] && cnt < 40) begin tick(); cnt++; end
        check("bp second data", data_out[0], model(1'b0, d2));
        out_ready[0] = 1'b1;
        tick();
        out_ready[0] = 1'b0;

        // Reset during beat 2 abandons the block
        in_valid[0] = 1'b1; data_in[0] = d1; en_or_de[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst out_valid", 128'(out_valid[0]), 128'(0));
        check("midrst busy", 128'(busy[0]), 128'(0));
        check("midrst data_out", data_out[0], 128'(0));
        check("midrst in_ready", 128'(in_ready[0]), 128'(1));
        tick();
        tick();
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) bad++;
        end
        check("midrst quiet after release", 128'(bad), 128'(0));

        // First rising edge after release accepts
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        in_valid[0] = 1'b1; data_in[0] = d2; en_or_de[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        check("first edge accept", 128'(busy[0]), 128'(1));
        cnt = 0;
        while (!out_valid[0] && cnt < 40) begin tick(); cnt++; end
        check("first edge data", data_out[0], model(1'b1, d2));
        out_ready[0] = 1'b1;
        tick();
        out_ready[0] = 1'b0;

        // Lane-count sweep
        for (int idx = 1; idx < NI; idx++) begin
            run_block(idx, vecs[0].mode, vecs[0].din, vecs[0].exp, $sformatf("sweep%0d vec0", idx));
            for (int r = 0; r < 2; r++) begin
                logic         m;
                logic [127:0] d;
                m = 1'($urandom_range(0, 1));
                d = rand_block();
                run_block(idx, m, d, model(m, d), $sformatf("sweep%0d rand%0d", idx, r));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/aes_subbytes_iter.md
AES_SUBBYTES_ITER -- requirements
Module: aes_subbytes_iter

Interface
REQ-001 Parameter NUM_BYTES, default 16, is the number of bytes per block.
REQ-002 Parameter LANES, default 4, is the number of S-box instances (bytes substituted per cycle).
REQ-003 Parameter constraint: LANES >= 1 and NUM_BYTES % LANES == 0. BEATS = NUM_BYTES/LANES. Elaboration SHALL fail otherwise.
REQ-004 clk  input  1  the only clock; all state SHALL update on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  input  1  upstream block valid.
REQ-007 in_ready  output  1  block can be accepted.
REQ-008 en_or_de  input  1  mode: 1 = forward S-box (encrypt), 0 = inverse S-box (decrypt); sampled with the block.
REQ-009 data_in  input  8*NUM_BYTES  input block; byte i = data_in[8i+7:8i].
REQ-010 out_valid  output  1  result block valid.
REQ-011 out_ready  input  1  downstream can accept.
REQ-012 data_out  output  8*NUM_BYTES  substituted block; byte i = S(byte i) or S^-1(byte i).
REQ-013 busy  output  1  high whenever state is not IDLE.

Function
REQ-014 The block SHALL use LANES instances of the existing combinational sbox_combi, with en_or_de of every instance driven from the latched mode.
REQ-015 FSM states: IDLE, BUSY, DONE. in_ready SHALL be 1 only in IDLE.
REQ-016 Accept = in_valid & in_ready at a rising edge. On accept: latch data_in and en_or_de, clear beat counter, go to BUSY.
REQ-017 In BUSY, beat k (0..BEATS-1) SHALL substitute bytes k*LANES .. k*LANES+LANES-1 and write them into the result register. Beat counter width is max(1, clog2(BEATS)).
REQ-018 After beat BEATS-1 the FSM SHALL go to DONE. out_valid SHALL be high exactly BEATS cycles after the accept edge (4 cycles at the defaults).
REQ-019 In DONE, out_valid SHALL stay 1 and data_out SHALL stay stable until out_valid & out_ready. On that edge the FSM SHALL return to IDLE. A new block SHALL NOT be accepted in the same cycle.
REQ-020 out_valid SHALL be 0 in IDLE and BUSY. out_ready SHALL be ignored outside DONE.
REQ-021 Changes on data_in, en_or_de or in_valid after accept SHALL NOT affect the block in progress.
REQ-022 data_out SHALL change only during BUSY beats. It SHALL hold the last result while idle.
REQ-023 BEATS = 1 (LANES = NUM_BYTES): BUSY SHALL last one cycle, giving a latency of 1.

Reset
REQ-024 rst_n low SHALL immediately force: state IDLE, beat counter 0, in_ready 1 (once rst_n is high), out_valid 0, busy 0, data_out 0, latched mode 1, latched data 0.
REQ-025 Reset during BUSY or DONE SHALL abandon the block. No out_valid pulse SHALL follow the reset release.
REQ-026 After rst_n deasserts, the first accept SHALL be possible on the first rising edge.

Verification
REQ-027 Defaults, en_or_de=1, data_in bytes 0..15 = 00,01,...,0f → after 4 cycles out_valid=1, data_out bytes = 63 7c 77 7b f2 6b 6f c5 30 01 67 2b fe d7 ab 76.
REQ-028 en_or_de=0, all bytes 63 → data_out all 00. All bytes 00 with en_or_de=0 → all 52. Byte ed with en_or_de=0 → 53.
REQ-029 Handshake test: hold out_ready=0 for 10 cycles in DONE → out_valid and data_out stable, in_ready=0. Then drive in_valid=1 and toggle data_in → nothing accepted until the cycle after the out handshake.
REQ-030 Mode latch: accept with en_or_de=1 and byte 53, flip en_or_de to 0 during BUSY → result byte ed.
REQ-031 Reset mid-block: assert rst_n=0 at beat 2 → outputs take reset values at once. After release, out_valid stays 0 and in_ready=1.
REQ-032 Parameter sweep: LANES = 1, 2, 16 with NUM_BYTES = 16 → latency 16, 8, 1 cycles, and results identical to REQ-027.
